// File: rtl/approx_mul_pkg.sv
// Shared types and constant helpers for the approximate sequential multiplier.
// Helpers work on 64-bit vectors so the product width 2*W may be at most 64.
package approx_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Vector with the n lowest bits set (saturates at 64 bits).
    function automatic logic [63:0] low_ones(input int unsigned n);
        logic [63:0] r;
        if (n >= 32'd64) begin
            r = {64{1'b1}};
        end else begin
            r = (64'd1 << n) - 64'd1;
        end
        return r;
    endfunction

    // Keeps columns [width-1:trunc]; columns below trunc are dropped in approximate mode.
    function automatic logic [63:0] trunc_mask(input int unsigned trunc, input int unsigned width);
        return low_ones(width) & ~low_ones(trunc);
    endfunction

    // Bias that re-centres the truncation error: half the weight of the lowest kept column.
    function automatic logic [63:0] bias(input int unsigned trunc);
        logic [63:0] r;
        if (trunc == 32'd0) begin
            r = 64'd0;
        end else begin
            r = 64'd1 << (trunc - 32'd1);
        end
        return r;
    endfunction

    // Width of the bit counter for a W-bit multiplier (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned r;
        if (w > 32'd1) begin
            r = $clog2(w);
        end else begin
            r = 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_mul_seq_pp_row.sv
// One partial-product row: multiplicand shifted to column i, with the
// low columns removed in approximate mode. Other approximation schemes
// are meant to replace this module without touching the sequencer.
module approx_pp_row
    import approx_mul_pkg::*;
#(
    parameter int W     = 8,
    parameter int TRUNC = 4,
    parameter int CW    = 3
) (
    input  logic [W-1:0]   a,
    input  logic [CW-1:0]  i,
    input  logic           approx,
    output logic [2*W-1:0] row
);

    localparam logic [63:0]    MASK_FULL = trunc_mask(TRUNC, 2 * W);
    localparam logic [2*W-1:0] MASK      = MASK_FULL[2*W-1:0];

    logic [2*W-1:0] shifted_s;

    // Shift the multiplicand into place and apply the column truncation.
    always_comb begin
        shifted_s = {{W{1'b0}}, a} << i;
        if (approx) begin
            row = shifted_s & MASK;
        end else begin
            row = shifted_s;
        end
    end

endmodule

// File: rtl/approx_mul_seq.sv
// Sequential shift-add unsigned multiplier with a per-operation choice of
// exact or column-truncated product, optional bias compensation and
// optional early termination. One multiplier bit is consumed per cycle;
// operands and results move on valid/ready handshakes with no overlap.
module approx_mul_seq
    import approx_mul_pkg::*;
#(
    parameter int W          = 8,
    parameter int TRUNC      = 4,
    parameter int COMP       = 1,
    parameter int EARLY_TERM = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_approx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_o,
    output logic           out_approx,
    output logic           busy
);

    localparam int             CW        = cnt_width(W);
    localparam logic [CW-1:0]  LAST_IDX  = CW'(W - 1);
    localparam logic [63:0]    BIAS_FULL = bias(TRUNC);
    localparam logic [2*W-1:0] BIAS_V    = BIAS_FULL[2*W-1:0];
    localparam bit             COMP_EN   = (COMP != 0) && (TRUNC > 0);
    localparam bit             ET_EN     = (EARLY_TERM != 0);

    state_e         state_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           approx_r;
    logic [2*W-1:0] acc_r;
    logic [CW-1:0]  cnt_r;

    logic           in_ready_r;
    logic           out_valid_r;
    logic [2*W-1:0] out_o_r;
    logic           out_approx_r;
    logic           busy_r;

    logic [2*W-1:0] row_s;
    logic [2*W-1:0] acc_next_s;
    logic [W-1:0]   upper_b_s;
    logic           last_s;
    logic [2*W-1:0] bias_s;
    logic [2*W:0]   sum_s;
    logic [2*W-1:0] result_s;

    approx_pp_row #(
        .W     (W),
        .TRUNC (TRUNC),
        .CW    (CW)
    ) u_pp_row (
        .a      (a_r),
        .i      (cnt_r),
        .approx (approx_r),
        .row    (row_s)
    );

    // Accumulate the current row and decide whether this is the final step.
    always_comb begin
        acc_next_s = acc_r;
        upper_b_s  = (b_r >> cnt_r) >> 1;
        last_s     = 1'b0;
        if (b_r[cnt_r]) begin
            acc_next_s = acc_r + row_s;
        end else begin
            acc_next_s = acc_r;
        end
        if (cnt_r == LAST_IDX) begin
            last_s = 1'b1;
        end else if (ET_EN && (upper_b_s == {W{1'b0}})) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Final result: optional bias, clamped to the product range.
    always_comb begin
        bias_s   = {(2*W){1'b0}};
        result_s = {(2*W){1'b0}};
        if (approx_r && COMP_EN) begin
            bias_s = BIAS_V;
        end else begin
            bias_s = {(2*W){1'b0}};
        end
        sum_s = {1'b0, acc_next_s} + {1'b0, bias_s};
        if (sum_s[2*W]) begin
            result_s = {(2*W){1'b1}};
        end else begin
            result_s = sum_s[2*W-1:0];
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            approx_r     <= 1'b0;
            acc_r        <= {(2*W){1'b0}};
            cnt_r        <= {CW{1'b0}};
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_o_r      <= {(2*W){1'b0}};
            out_approx_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        approx_r   <= in_approx;
                        acc_r      <= {(2*W){1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    if (last_s) begin
                        out_o_r      <= result_s;
                        out_approx_r <= approx_r;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_o      = out_o_r;
    assign out_approx = out_approx_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_approx_mul_seq.sv
// Self-checking bench for approx_mul_seq: four instances with different
// truncation/compensation/early-termination settings, an arithmetic model
// of the product and latency, and one monitor comparing outputs each cycle.
module tb_approx_mul_seq;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv   [N];
    logic       ir   [N];
    logic [7:0] ia   [N];
    logic [7:0] ib   [N];
    logic       iap  [N];
    logic       ov   [N];
    logic       ordy [N];
    logic [15:0] oo  [N];
    logic       oap  [N];
    logic       bsy  [N];

    longint exp_val [N];
    bit     exp_ap  [N];
    int     exp_lat [N];
    int     acc_cyc [N];
    bit     pending [N];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    approx_mul_seq #(.W(8), .TRUNC(4), .COMP(1), .EARLY_TERM(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
        .in_approx(iap[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_o(oo[0]),
        .out_approx(oap[0]), .busy(bsy[0]));
    approx_mul_seq #(.W(8), .TRUNC(4), .COMP(0), .EARLY_TERM(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
        .in_approx(iap[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_o(oo[1]),
        .out_approx(oap[1]), .busy(bsy[1]));
    approx_mul_seq #(.W(8), .TRUNC(9), .COMP(1), .EARLY_TERM(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]),
        .in_approx(iap[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_o(oo[2]),
        .out_approx(oap[2]), .busy(bsy[2]));
    approx_mul_seq #(.W(8), .TRUNC(0), .COMP(1), .EARLY_TERM(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_a(ia[3]), .in_b(ib[3]),
        .in_approx(iap[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_o(oo[3]),
        .out_approx(oap[3]), .busy(bsy[3]));

    function automatic int tr_of(input int k);
        case (k)
            0: return 4;
            1: return 4;
            2: return 9;
            default: return 0;
        endcase
    endfunction

    function automatic int cp_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int et_of(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    // Product model: each set multiplier bit contributes a*2^i; approximate
    // mode discards the part of that contribution worth less than 2^trunc.
    function automatic longint ref_mul(input int a, input int b, input bit ap,
                                       input int trunc, input int comp);
        longint s = 0;
        longint row;
        longint unit = longint'(1) << trunc;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) == 1) begin
                row = longint'(a) * (longint'(1) << i);
                if (ap) row = row - (row % unit);
                s = s + row;
            end
        end
        if (ap && comp != 0 && trunc > 0) s = s + (longint'(1) << (trunc - 1));
        if (s > 65535) s = 65535;
        return s;
    endfunction

    function automatic int lat_of(input int k, input int b);
        int l = 1;
        if (et_of(k) == 0) return 8;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) l = i + 1;
        return l;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every valid output cycle against the outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < N; k++) begin
                if (ov[k] === 1'b1) begin
                    chk($sformatf("d%0d_valid_expected", k), 1, longint'(pending[k]));
                    if (pending[k]) begin
                        chk($sformatf("d%0d_out_o", k), longint'(oo[k]), exp_val[k]);
                        chk($sformatf("d%0d_out_approx", k), longint'(oap[k]), longint'(exp_ap[k]));
                        chk($sformatf("d%0d_in_ready_low", k), longint'(ir[k]), 0);
                        chk($sformatf("d%0d_busy_high", k), longint'(bsy[k]), 1);
                    end
                end
            end
        end
    end

    task automatic accept_op(input int k, input int a, input int b, input bit ap, output bit ok);
        int w = 0;
        ok = 1'b0;
        @(negedge clk);
        while (ir[k] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (ir[k] !== 1'b1) begin
            chk($sformatf("d%0d_accept_timeout", k), 0, 1);
            return;
        end
        exp_val[k] = ref_mul(a, b, ap, tr_of(k), cp_of(k));
        exp_ap[k]  = ap;
        exp_lat[k] = lat_of(k, b);
        pending[k] = 1'b1;
        iv[k]  = 1'b1;
        ia[k]  = 8'(a);
        ib[k]  = 8'(b);
        iap[k] = ap;
        @(posedge clk);
        #1;
        acc_cyc[k] = cyc;
        iv[k]  = 1'b0;
        iap[k] = ~ap;
        ia[k]  = 8'($urandom);
        ib[k]  = 8'($urandom);
        ok = 1'b1;
    endtask

    task automatic collect_op(input int k, input int hold, output longint res, output int lat);
        int w = 0;
        res = 0;
        lat = 0;
        while (ov[k] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (ov[k] !== 1'b1) begin
            chk($sformatf("d%0d_result_timeout", k), 0, 1);
            pending[k] = 1'b0;
            return;
        end
        lat = cyc - acc_cyc[k];
        res = longint'(oo[k]);
        chk($sformatf("d%0d_latency", k), lat, exp_lat[k]);
        for (int h = 0; h < hold; h++) begin
            iv[k] = 1'b1;
            ia[k] = 8'($urandom);
            ib[k] = 8'($urandom);
            @(negedge clk);
        end
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        iv[k]   = 1'b0;
        pending[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("d%0d_ready_after_handshake", k), longint'(ir[k]), 1);
        chk($sformatf("d%0d_valid_drop", k), longint'(ov[k]), 0);
    endtask

    task automatic do_op(input int k, input int a, input int b, input bit ap, input int hold,
                         output longint res, output int lat);
        bit ok;
        res = 0;
        lat = 0;
        accept_op(k, a, b, ap, ok);
        if (ok) collect_op(k, hold, res, lat);
    endtask

    task automatic sweep(input int k, input int n);
        longint res;
        int lat;
        int a, b, hold;
        bit ap;
        for (int j = 0; j < n; j++) begin
            a    = $urandom_range(0, 255);
            b    = $urandom_range(0, 255) >> $urandom_range(0, 7);
            ap   = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            do_op(k, a, b, ap, hold, res, lat);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint res;
        int lat;
        bit ok;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0; ia[k] = 8'd0; ib[k] = 8'd0; iap[k] = 1'b0; ordy[k] = 1'b0;
            pending[k] = 1'b0; exp_val[k] = 0; exp_ap[k] = 1'b0; exp_lat[k] = 0; acc_cyc[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("d%0d_rst_in_ready", k), longint'(ir[k]), 1);
            chk($sformatf("d%0d_rst_out_valid", k), longint'(ov[k]), 0);
            chk($sformatf("d%0d_rst_out_o", k), longint'(oo[k]), 0);
            chk($sformatf("d%0d_rst_out_approx", k), longint'(oap[k]), 0);
            chk($sformatf("d%0d_rst_busy", k), longint'(bsy[k]), 0);
        end
        rst_n = 1'b1;

        // Pin the model with hand-computed values.
        chk("model_exact_200x150", ref_mul(200, 150, 1'b0, 4, 1), 30000);
        chk("model_t4_comp", ref_mul(255, 255, 1'b1, 4, 1), 64984);
        chk("model_t4_nocomp", ref_mul(255, 255, 1'b1, 4, 0), 64976);
        chk("model_t0_nobias", ref_mul(255, 255, 1'b1, 0, 1), 65025);
        chk("model_t9_comp", ref_mul(255, 255, 1'b1, 9, 1), 61696);
        chk("model_lat_b3", lat_of(2, 3), 2);
        chk("model_lat_b0", lat_of(2, 0), 1);
        chk("model_lat_b128", lat_of(2, 128), 8);
        chk("model_lat_noet", lat_of(0, 3), 8);

        // Directed operations with literal expectations.
        do_op(0, 200, 150, 1'b0, 0, res, lat);
        chk("exact_200x150", res, 30000);
        chk("exact_latency", lat, 8);
        do_op(0, 255, 255, 1'b1, 0, res, lat);
        chk("approx_t4_comp", res, 64984);
        do_op(1, 255, 255, 1'b1, 0, res, lat);
        chk("approx_t4_nocomp", res, 64976);
        do_op(3, 255, 255, 1'b1, 0, res, lat);
        chk("approx_t0_exact", res, 65025);
        do_op(2, 255, 255, 1'b1, 0, res, lat);
        chk("approx_t9_comp", res, 61696);
        do_op(2, 100, 3, 1'b0, 0, res, lat);
        chk("et_b3_val", res, 300);
        chk("et_b3_lat", lat, 2);
        do_op(2, 100, 0, 1'b0, 0, res, lat);
        chk("et_b0_val", res, 0);
        chk("et_b0_lat", lat, 1);
        do_op(2, 100, 128, 1'b0, 0, res, lat);
        chk("et_b128_val", res, 12800);
        chk("et_b128_lat", lat, 8);

        // Backpressure: result held for 5 cycles while new requests are offered.
        do_op(0, 7, 9, 1'b0, 5, res, lat);
        chk("bp_held_val", res, 63);
        do_op(0, 17, 19, 1'b0, 0, res, lat);
        chk("bp_next_val", res, 323);

        // Reset in the middle of RUN aborts the operation.
        accept_op(0, 50, 60, 1'b0, ok);
        @(negedge clk);
        @(negedge clk);
        chk("midrun_busy_before_reset", longint'(bsy[0]), 1);
        pending[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", longint'(ir[0]), 1);
        chk("midrun_rst_out_valid", longint'(ov[0]), 0);
        chk("midrun_rst_out_o", longint'(oo[0]), 0);
        chk("midrun_rst_busy", longint'(bsy[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 15, 15, 1'b0, 0, res, lat);
        chk("after_reset_val", res, 225);
        chk("after_reset_lat", lat, 8);

        // Randomised sweep on all configurations in parallel.
        fork
            sweep(0, 2000);
            sweep(1, 2000);
            sweep(2, 2000);
            sweep(3, 2000);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
